// File: rtl/atm_session_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : atm_session_ctrl_if
// Front-end / controller bundle: config port, session strobes and response.
// Rev    : 1.0
// ============================================================================
interface atm_session_ctrl_if #(
    parameter int NUM_CARDS = 5,
    parameter int CARD_W    = 32,
    parameter int PIN_W     = 20,
    parameter int AMT_W     = 32
);
    localparam int IDX_W = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;

    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [CARD_W-1:0] cfg_card;
    logic [PIN_W-1:0]  cfg_pin;
    logic [AMT_W-1:0]  cfg_bal;
    logic              start;
    logic              card_valid;
    logic [CARD_W-1:0] card_num;
    logic              pin_valid;
    logic [PIN_W-1:0]  pin;
    logic              txn_valid;
    logic [2:0]        txn;
    logic [AMT_W-1:0]  amount;
    logic              busy;
    logic [2:0]        state_o;
    logic              resp_valid;
    logic [2:0]        resp_code;
    logic [AMT_W-1:0]  balance_o;

    modport master (
        output cfg_we, cfg_idx, cfg_card, cfg_pin, cfg_bal,
        output start, card_valid, card_num, pin_valid, pin,
        output txn_valid, txn, amount,
        input  busy, state_o, resp_valid, resp_code, balance_o
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_card, cfg_pin, cfg_bal,
        input  start, card_valid, card_num, pin_valid, pin,
        input  txn_valid, txn, amount,
        output busy, state_o, resp_valid, resp_code, balance_o
    );
endinterface
`default_nettype wire

// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module : atm_session_ctrl
// Multi-account ATM session controller: card lookup, PIN lockout, transactions.
// Rev    : 1.0
// ============================================================================
module atm_session_ctrl #(
    parameter int NUM_CARDS   = 5,
    parameter int CARD_W      = 32,
    parameter int PIN_W       = 20,
    parameter int AMT_W       = 32,
    parameter int MAX_TRIES   = 3,
    parameter int WDR_LIMIT   = 20000,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    atm_session_ctrl_if.slave bus
);
    localparam int IDX_W = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [AMT_W:0] c_WDR_LIMIT = (AMT_W + 1)'(WDR_LIMIT);

    localparam logic [2:0] c_RESP_OK       = 3'd0;
    localparam logic [2:0] c_RESP_BAD_CARD = 3'd1;
    localparam logic [2:0] c_RESP_BAD_PIN  = 3'd2;
    localparam logic [2:0] c_RESP_LOCKED   = 3'd3;
    localparam logic [2:0] c_RESP_INSUF    = 3'd4;
    localparam logic [2:0] c_RESP_LIMIT    = 3'd5;
    localparam logic [2:0] c_RESP_OVF      = 3'd6;
    localparam logic [2:0] c_RESP_TIMEOUT  = 3'd7;

    localparam logic [2:0] c_TXN_DEP  = 3'd1;
    localparam logic [2:0] c_TXN_WDR  = 3'd2;
    localparam logic [2:0] c_TXN_BAL  = 3'd3;
    localparam logic [2:0] c_TXN_EXIT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_CARD = 3'd1,
        S_SCAN      = 3'd2,
        S_WAIT_PIN  = 3'd3,
        S_MENU      = 3'd4,
        S_EXEC      = 3'd5,
        S_END       = 3'd6
    } state_t;

    // Account table storage has no reset so a mid-session reset cannot disturb balances.
    logic [CARD_W-1:0] r_card [NUM_CARDS];
    logic [PIN_W-1:0]  r_pin  [NUM_CARDS];
    logic [AMT_W-1:0]  r_bal  [NUM_CARDS];
    logic [NUM_CARDS-1:0] r_lock;
    logic [TRY_W-1:0]  r_tries [NUM_CARDS];

    state_t            r_state;
    logic [IDX_W-1:0]  r_scan_idx;
    logic [IDX_W-1:0]  r_act_idx;
    logic [CARD_W-1:0] r_card_lat;
    logic [2:0]        r_txn;
    logic [AMT_W-1:0]  r_amt;
    logic [AMT_W-1:0]  r_wdr_tot;
    logic [TMR_W-1:0]  r_timer;
    logic              r_resp_valid;
    logic [2:0]        r_resp_code;
    logic [AMT_W-1:0]  r_balance;

    logic              w_cfg_hit;
    logic [AMT_W-1:0]  w_cur_bal;
    logic [AMT_W:0]    w_dep_sum;
    logic [AMT_W:0]    w_wdr_sum;
    logic              w_dep_ovf;
    logic              w_wdr_insuf;
    logic              w_wdr_limit;
    logic              w_bal_we;
    logic [AMT_W-1:0]  w_bal_wdata;
    logic              w_scan_match;
    logic              w_scan_last;
    logic              w_pin_ok;
    logic [TRY_W-1:0]  w_tries_nx;
    logic              w_lock_now;
    logic              w_tmo;

    assign w_cfg_hit    = (r_state == S_IDLE) && bus.cfg_we &&
                          ({1'b0, bus.cfg_idx} < (IDX_W + 1)'(NUM_CARDS));
    assign w_cur_bal    = r_bal[r_act_idx];
    assign w_dep_sum    = {1'b0, w_cur_bal} + {1'b0, r_amt};
    assign w_wdr_sum    = {1'b0, r_wdr_tot} + {1'b0, r_amt};
    assign w_dep_ovf    = w_dep_sum[AMT_W];
    assign w_wdr_insuf  = r_amt > w_cur_bal;
    assign w_wdr_limit  = w_wdr_sum > c_WDR_LIMIT;
    assign w_scan_match = (r_card[r_scan_idx] == r_card_lat);
    assign w_scan_last  = (r_scan_idx == IDX_W'(NUM_CARDS - 1));
    assign w_pin_ok     = (bus.pin == r_pin[r_act_idx]);
    assign w_tries_nx   = r_tries[r_act_idx] + 1'b1;
    assign w_lock_now   = (w_tries_nx >= TRY_W'(MAX_TRIES));
    assign w_tmo        = (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    assign w_bal_we    = (r_state == S_EXEC) &&
                         (((r_txn == c_TXN_DEP) && !w_dep_ovf) ||
                          ((r_txn == c_TXN_WDR) && !w_wdr_insuf && !w_wdr_limit));
    assign w_bal_wdata = (r_txn == c_TXN_DEP) ? w_dep_sum[AMT_W-1:0] : (w_cur_bal - r_amt);

    always_ff @(posedge clk) begin
        if (w_cfg_hit) begin
            r_card[bus.cfg_idx] <= bus.cfg_card;
            r_pin[bus.cfg_idx]  <= bus.cfg_pin;
            r_bal[bus.cfg_idx]  <= bus.cfg_bal;
        end else if (w_bal_we) begin
            r_bal[r_act_idx] <= w_bal_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_scan_idx   <= '0;
            r_act_idx    <= '0;
            r_card_lat   <= '0;
            r_txn        <= '0;
            r_amt        <= '0;
            r_wdr_tot    <= '0;
            r_timer      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_code  <= '0;
            r_balance    <= '0;
            r_lock       <= '0;
            for (int i = 0; i < NUM_CARDS; i++) begin
                r_tries[i] <= '0;
            end
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cfg_we) begin
                        if (w_cfg_hit) begin
                            r_lock[bus.cfg_idx]  <= 1'b0;
                            r_tries[bus.cfg_idx] <= '0;
                        end
                    end else if (bus.start) begin
                        r_state <= S_WAIT_CARD;
                    end
                end
                S_WAIT_CARD: begin
                    if (bus.card_valid) begin
                        if (bus.card_num == '0) begin
                            r_resp_valid <= 1'b1;
                            r_resp_code  <= c_RESP_BAD_CARD;
                            r_state      <= S_IDLE;
                        end else begin
                            r_card_lat <= bus.card_num;
                            r_scan_idx <= '0;
                            r_state    <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_scan_match) begin
                        if (r_lock[r_scan_idx]) begin
                            r_resp_valid <= 1'b1;
                            r_resp_code  <= c_RESP_LOCKED;
                            r_state      <= S_IDLE;
                        end else begin
                            r_act_idx <= r_scan_idx;
                            r_timer   <= '0;
                            r_state   <= S_WAIT_PIN;
                        end
                    end else if (w_scan_last) begin
                        r_resp_valid <= 1'b1;
                        r_resp_code  <= c_RESP_BAD_CARD;
                        r_state      <= S_IDLE;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                S_WAIT_PIN: begin
                    if (bus.pin_valid) begin
                        r_timer      <= '0;
                        r_resp_valid <= 1'b1;
                        if (w_pin_ok) begin
                            r_resp_code        <= c_RESP_OK;
                            r_balance          <= w_cur_bal;
                            r_tries[r_act_idx] <= '0;
                            r_wdr_tot          <= '0;
                            r_state            <= S_MENU;
                        end else begin
                            r_tries[r_act_idx] <= w_tries_nx;
                            if (w_lock_now) begin
                                r_lock[r_act_idx] <= 1'b1;
                                r_resp_code       <= c_RESP_LOCKED;
                                r_state           <= S_IDLE;
                            end else begin
                                r_resp_code <= c_RESP_BAD_PIN;
                            end
                        end
                    end else if (w_tmo) begin
                        r_timer      <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_code  <= c_RESP_TIMEOUT;
                        r_state      <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_MENU: begin
                    if (bus.txn_valid) begin
                        r_timer <= '0;
                        r_txn   <= bus.txn;
                        r_amt   <= bus.amount;
                        if (bus.txn == c_TXN_EXIT) begin
                            r_resp_valid <= 1'b1;
                            r_resp_code  <= c_RESP_OK;
                            r_balance    <= w_cur_bal;
                            r_state      <= S_END;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end else if (w_tmo) begin
                        r_timer      <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_code  <= c_RESP_TIMEOUT;
                        r_state      <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_EXEC: begin
                    r_timer      <= '0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_MENU;
                    case (r_txn)
                        c_TXN_DEP: begin
                            if (w_dep_ovf) begin
                                r_resp_code <= c_RESP_OVF;
                            end else begin
                                r_resp_code <= c_RESP_OK;
                                r_balance   <= w_bal_wdata;
                            end
                        end
                        c_TXN_WDR: begin
                            if (w_wdr_insuf) begin
                                r_resp_code <= c_RESP_INSUF;
                            end else if (w_wdr_limit) begin
                                r_resp_code <= c_RESP_LIMIT;
                            end else begin
                                r_resp_code <= c_RESP_OK;
                                r_balance   <= w_bal_wdata;
                                r_wdr_tot   <= w_wdr_sum[AMT_W-1:0];
                            end
                        end
                        c_TXN_BAL: begin
                            r_resp_code <= c_RESP_OK;
                            r_balance   <= w_cur_bal;
                        end
                        default: begin
                            r_resp_code <= c_RESP_OVF;
                        end
                    endcase
                end
                S_END: begin
                    r_wdr_tot  <= '0;
                    r_timer    <= '0;
                    r_act_idx  <= '0;
                    r_scan_idx <= '0;
                    r_card_lat <= '0;
                    r_txn      <= '0;
                    r_amt      <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.state_o    = r_state;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_code  = r_resp_code;
    assign bus.balance_o  = r_balance;

endmodule
`default_nettype wire
